// File: rtl/lsm_readout.sv
`default_nettype none
// lsm_readout: per-neuron spike counting over a window, then a serial Q4.12
// linear readout (one MAC per cycle) with argmax over K classes. Rev 1.0
module lsm_readout #(
  parameter int N      = 64,
  parameter int K      = 4,
  parameter int WINDOW = 32,
  parameter int CW     = $clog2(WINDOW+1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           spikes_in,
  input  logic                   spikes_valid,
  input  logic                   start,
  input  logic                   w_we,
  input  logic [$clog2(N*K)-1:0] w_addr,
  input  logic signed [15:0]     w_data,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [$clog2(K)-1:0]   class_out,
  output logic signed [31:0]     score_out
);
  localparam int AW = $clog2(N*K);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);
  localparam int PW = CW + 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    MAC     = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state;
  logic [CW-1:0]      counts [N];
  logic [CW-1:0]      sample_cnt;
  logic [KW-1:0]      k_idx;
  logic [NW-1:0]      n_idx;
  logic               issue_done;
  logic               prod_vld;
  logic               prod_last_n;
  logic [KW-1:0]      prod_k;
  logic signed [31:0] prod_q;
  logic signed [31:0] acc;
  logic signed [31:0] best_score;
  logic [KW-1:0]      best_class;
  logic signed [15:0] weights [N*K];

  logic [AW-1:0]        rd_addr;
  logic signed [15:0]   rd_weight;
  logic signed [CW:0]   cnt_s;
  logic signed [PW-1:0] cnt_ext;
  logic signed [PW-1:0] w_ext;
  logic signed [PW-1:0] product;
  logic signed [31:0]   acc_sum;
  logic                 new_best;

  assign rd_addr   = AW'(int'(k_idx) * N + int'(n_idx));
  assign rd_weight = weights[rd_addr];
  assign cnt_s     = {1'b0, counts[n_idx]};
  assign cnt_ext   = PW'(cnt_s);
  assign w_ext     = PW'(rd_weight);
  assign product   = cnt_ext * w_ext;
  assign acc_sum   = acc + prod_q;
  assign new_best  = acc_sum > best_score;

  // Weight store has no reset; the host owns its contents.
  always_ff @(posedge clk) begin
    if (w_we && state != MAC)
      weights[w_addr] <= w_data;
  end

  // Two-stage MAC: the product of (k,n) is registered, then accumulated on
  // the next edge, so the final compare lands one edge after the last issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      for (int i = 0; i < N; i++) counts[i] <= '0;
      sample_cnt   <= '0;
      k_idx        <= '0;
      n_idx        <= '0;
      issue_done   <= 1'b0;
      prod_vld     <= 1'b0;
      prod_last_n  <= 1'b0;
      prod_k       <= '0;
      prod_q       <= '0;
      acc          <= '0;
      best_score   <= '0;
      best_class   <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_out    <= '0;
      score_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COLLECT;
            busy       <= 1'b1;
            sample_cnt <= '0;
          end
        end
        COLLECT: begin
          if (spikes_valid) begin
            for (int i = 0; i < N; i++)
              counts[i] <= counts[i] + CW'(spikes_in[i]);
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == CW'(WINDOW-1)) begin
              state      <= MAC;
              k_idx      <= '0;
              n_idx      <= '0;
              acc        <= '0;
              best_score <= 32'sh8000_0000;
              best_class <= '0;
              issue_done <= 1'b0;
              prod_vld   <= 1'b0;
            end
          end
        end
        MAC: begin
          prod_vld <= !issue_done;
          if (!issue_done) begin
            prod_q      <= 32'(product);
            prod_k      <= k_idx;
            prod_last_n <= (n_idx == NW'(N-1));
            if (n_idx == NW'(N-1)) begin
              n_idx <= '0;
              if (k_idx == KW'(K-1)) issue_done <= 1'b1;
              else                   k_idx      <= k_idx + 1'b1;
            end else begin
              n_idx <= n_idx + 1'b1;
            end
          end
          if (prod_vld) begin
            if (prod_last_n) begin
              acc <= '0;
              if (new_best) begin
                best_score <= acc_sum;
                best_class <= prod_k;
              end
              if (prod_k == KW'(K-1)) begin
                state        <= HOLD;
                result_valid <= 1'b1;
                class_out    <= new_best ? prod_k : best_class;
                score_out    <= new_best ? acc_sum : best_score;
              end
            end else begin
              acc <= acc_sum;
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            for (int i = 0; i < N; i++) counts[i] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lsm_readout.sv
`default_nettype none
// tb_lsm_readout: directed and randomized checks against a count/score model.
// Rev 1.0
module tb_lsm_readout;
  localparam int N      = 64;
  localparam int K      = 4;
  localparam int WINDOW = 32;
  localparam int AW     = $clog2(N*K);

  logic               clk = 1'b0;
  logic               reset_n;
  logic [N-1:0]       spikes_in;
  logic               spikes_valid;
  logic               start;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic signed [15:0] w_data;
  logic               busy;
  logic               result_valid;
  logic               result_ready;
  logic [1:0]         class_out;
  logic signed [31:0] score_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] wm [N*K];
  int                 cnt_m [N];

  lsm_readout #(.N(N), .K(K), .WINDOW(WINDOW)) dut (
    .clk(clk), .reset_n(reset_n), .spikes_in(spikes_in),
    .spikes_valid(spikes_valid), .start(start), .w_we(w_we),
    .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .class_out(class_out), .score_out(score_out)
  );

  always #5 clk = ~clk;

  // Scores straight from the definition: sum of count * weight, strict argmax.
  function automatic void model_result(output int cls, output longint score);
    longint s;
    cls   = 0;
    score = -64'sd2147483648;
    for (int k = 0; k < K; k++) begin
      s = 0;
      for (int n = 0; n < N; n++)
        s += longint'(cnt_m[n]) * longint'(wm[k*N+n]);
      if (s > score) begin
        score = s;
        cls   = k;
      end
    end
  endfunction

  function automatic int expected_edges(input int gap);
    return (WINDOW-1)*(gap+1) + 1 + N*K + 1;
  endfunction

  task automatic write_weight(input int addr, input logic signed [15:0] data);
    w_we   = 1'b1;
    w_addr = AW'(addr);
    w_data = data;
    @(posedge clk); #1;
    w_we   = 1'b0;
    wm[addr] = data;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  // Starts a window from the current cycle, feeds WINDOW valid samples with
  // 'gap' idle cycles between them, and waits (bounded) for result_valid.
  task automatic run_window(input int gap, input bit rnd, input logic [N-1:0] pat,
                            input bit noise, output bit busy_s, output int edges,
                            output bit got);
    int sent;
    int phase;
    logic [N-1:0] s;
    for (int n = 0; n < N; n++) cnt_m[n] = 0;
    start        = 1'b1;
    spikes_valid = 1'b1;
    spikes_in    = {$urandom, $urandom};
    @(posedge clk); #1;
    busy_s = busy;
    start  = 1'b0;
    sent   = 0;
    phase  = 0;
    edges  = 0;
    got    = 1'b0;
    while (edges < 2000 && !got) begin
      if (sent < WINDOW) begin
        if (phase == 0) begin
          s = rnd ? {$urandom, $urandom} : pat;
          spikes_in    = s;
          spikes_valid = 1'b1;
          for (int n = 0; n < N; n++) cnt_m[n] += int'(s[n]);
          sent++;
        end else begin
          spikes_valid = 1'b0;
          spikes_in    = {$urandom, $urandom};
        end
        phase = (phase == gap) ? 0 : phase + 1;
      end else begin
        spikes_valid = 1'($urandom_range(0, 1));
        spikes_in    = {$urandom, $urandom};
        if (noise) begin
          start  = 1'($urandom_range(0, 1));
          w_we   = 1'b1;
          w_addr = AW'($urandom_range(0, N*K-1));
          w_data = 16'($urandom);
        end
      end
      @(posedge clk); #1;
      edges++;
      if (result_valid) got = 1'b1;
    end
    start        = 1'b0;
    w_we         = 1'b0;
    spikes_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({busy, result_valid, class_out, score_out} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 0", {busy, result_valid, class_out, score_out});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, result_valid, class_out, score_out} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0", {busy, result_valid, class_out, score_out});
    end
  endtask

  task automatic check_single(input string tag);
    bit busy_s;
    bit got;
    int edges;
    logic [N-1:0] p;
    p = '0;
    p[5] = 1'b1;
    run_window(0, 1'b0, p, 1'b0, busy_s, edges, got);
    n_checks++;
    if (busy_s !== 1'b1) begin
      n_fail++; $display("FAIL %s_busy_rise: got %0d expected 1", tag, busy_s);
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL %s_timeout: no result_valid within %0d edges", tag, edges);
    end
    n_checks++;
    if (edges != expected_edges(0)) begin
      n_fail++; $display("FAIL %s_latency: got %0d expected %0d", tag, edges, expected_edges(0));
    end
    n_checks++;
    if (class_out !== 2'd2) begin
      n_fail++; $display("FAIL %s_class: got %0d expected 2", tag, class_out);
    end
    n_checks++;
    if (score_out !== 32'sd131072) begin
      n_fail++; $display("FAIL %s_score: got %0d expected 131072", tag, score_out);
    end
  endtask

  task automatic test_single_weight();
    for (int i = 0; i < N*K; i++) write_weight(i, 16'sd0);
    write_weight(2*N+5, 16'sd4096);
    check_single("single");
    handshake();
    n_checks++;
    if ({result_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_release: got valid=%0d busy=%0d expected 0 0", result_valid, busy);
    end
    n_checks++;
    if (class_out !== 2'd2 || score_out !== 32'sd131072) begin
      n_fail++; $display("FAIL single_idle_hold: got %0d/%0d expected 2/131072", class_out, score_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] p;
    p = '0;
    p[5] = 1'b1;
    // mid-MAC
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; spikes_valid = 1'b1; spikes_in = p;
    repeat (WINDOW) @(posedge clk);
    #1 spikes_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mac_busy: got %0d expected 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, result_valid, class_out, score_out} !== 36'd0) begin
      n_fail++; $display("FAIL reset_mid_mac: got %h expected 0", {busy, result_valid, class_out, score_out});
    end
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    // mid-COLLECT
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; spikes_valid = 1'b1; spikes_in = p;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL collect_busy: got %0d expected 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, result_valid, class_out, score_out} !== 36'd0) begin
      n_fail++; $display("FAIL reset_mid_collect: got %h expected 0", {busy, result_valid, class_out, score_out});
    end
    #1 reset_n = 1'b1;
    spikes_valid = 1'b0;
    @(posedge clk); #1;
    check_single("after_reset");
    handshake();
  endtask

  task automatic test_tie_break();
    bit busy_s;
    bit got;
    int edges;
    for (int i = 0; i < N*K; i++) write_weight(i, 16'sd0);
    run_window(0, 1'b1, '0, 1'b0, busy_s, edges, got);
    n_checks++;
    if (!got || class_out !== 2'd0 || score_out !== 32'sd0) begin
      n_fail++; $display("FAIL tie_break: got valid=%0d class=%0d score=%0d expected 1/0/0", got, class_out, score_out);
    end
    handshake();
  endtask

  task automatic test_negative();
    bit busy_s;
    bit got;
    int edges;
    for (int i = 0; i < N*K; i++)
      write_weight(i, (i >= 3*N) ? -16'sd1 : -16'sd4096);
    run_window(0, 1'b0, '1, 1'b0, busy_s, edges, got);
    n_checks++;
    if (!got || class_out !== 2'd3) begin
      n_fail++; $display("FAIL negative_class: got %0d expected 3", class_out);
    end
    n_checks++;
    if (score_out !== -32'sd2048) begin
      n_fail++; $display("FAIL negative_score: got %0d expected -2048", score_out);
    end
    handshake();
  endtask

  task automatic test_gaps_backpressure();
    bit busy_s;
    bit got;
    int edges;
    logic [N-1:0] p;
    p = '0;
    p[0] = 1'b1;
    for (int i = 0; i < N*K; i++) write_weight(i, 16'sd0);
    write_weight(1*N+0, 16'sd100);
    for (int r = 0; r < 2; r++) begin
      run_window(1, 1'b0, p, 1'b1, busy_s, edges, got);
      n_checks++;
      if (edges != expected_edges(1)) begin
        n_fail++; $display("FAIL gap_latency_%0d: got %0d expected %0d", r, edges, expected_edges(1));
      end
      n_checks++;
      if (!got || class_out !== 2'd1 || score_out !== 32'sd3200) begin
        n_fail++; $display("FAIL gap_result_%0d: got class=%0d score=%0d expected 1/3200", r, class_out, score_out);
      end
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        n_checks++;
        if (result_valid !== 1'b1 || class_out !== 2'd1 || score_out !== 32'sd3200) begin
          n_fail++; $display("FAIL backpressure_hold: cycle %0d got valid=%0d class=%0d score=%0d", c, result_valid, class_out, score_out);
        end
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    bit busy_s;
    bit got;
    int edges;
    int ecls;
    longint escore;
    for (int i = 0; i < N*K; i++) write_weight(i, 16'($urandom));
    for (int r = 0; r < 3; r++) begin
      run_window(0, 1'b1, '0, 1'b0, busy_s, edges, got);
      model_result(ecls, escore);
      n_checks++;
      if (busy_s !== 1'b1 || edges != expected_edges(0)) begin
        n_fail++; $display("FAIL b2b_start_%0d: got busy=%0d edges=%0d expected 1/%0d", r, busy_s, edges, expected_edges(0));
      end
      n_checks++;
      if (class_out !== 2'(ecls) || score_out !== 32'(escore)) begin
        n_fail++; $display("FAIL b2b_result_%0d: got %0d/%0d expected %0d/%0d", r, class_out, score_out, ecls, escore);
      end
      handshake();
    end
  endtask

  task automatic test_random();
    bit busy_s;
    bit got;
    int edges;
    int gap;
    int ecls;
    longint escore;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N*K; i++) write_weight(i, 16'($urandom));
      gap = $urandom_range(0, 2);
      run_window(gap, 1'b1, '0, 1'b1, busy_s, edges, got);
      model_result(ecls, escore);
      n_checks++;
      if (!got || edges != expected_edges(gap)) begin
        n_fail++; $display("FAIL random_latency_%0d: got %0d expected %0d", r, edges, expected_edges(gap));
      end
      n_checks++;
      if (class_out !== 2'(ecls) || score_out !== 32'(escore)) begin
        n_fail++; $display("FAIL random_result_%0d: got %0d/%0d expected %0d/%0d", r, class_out, score_out, ecls, escore);
      end
      handshake();
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    spikes_in    = '0;
    spikes_valid = 1'b0;
    start        = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_data       = '0;
    result_ready = 1'b0;
    test_reset();
    test_single_weight();
    test_reset_mid();
    test_tie_break();
    test_negative();
    test_gaps_backpressure();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
